// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART command frame parser issuing target memory read/write requests
//
// Purpose:
//   Parses byte frames from a UART receiver into one-cycle memory access
//   requests, and answers over the UART transmitter: 0x55 for a completed
//   write, 0xEE (NAK) when the CPU is running or a read times out, or the
//   6-byte read-back word for a read.
//   Frame: CMD (0xA in [7:4], [1] = mem type, [0] = write), ADDR_HI ([0] is
//   address bit 8), ADDR_LO, then 4 data bytes MSB-first for writes only.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   rx_data, rx_valid   - received byte and its one-cycle strobe
//   enable              - CPU run flag; memory access only while low
//   mem_tx_data_in      - read-back word {valid, addr[8:0], data[31:0]}
//   mem_tx_data_ready   - read-back strobe
//   tx_ready            - transmitter accepts tx_data when tx_valid is high
//   write_mem_req       - one-cycle memory access request
//   target_mem_type     - 1 = instruction memory, 0 = data memory
//   target_addr         - word address
//   uart_rx_data_in     - write data
//   rw_flag             - 1 = write, 0 = read
//   tx_data, tx_valid   - byte to transmitter
//   frame_err           - one-cycle pulse on rejected, overrun or timed-out frame
//
// Configuration:
//   CMD_TIMEOUT_EN - when defined, a frame or read response that stalls for
//                    TIMEOUT_CYCLES cycles is abandoned.

module uart_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        enable,
  input  logic [41:0] mem_tx_data_in,
  input  logic        mem_tx_data_ready,
  input  logic        tx_ready,
  output logic        write_mem_req,
  output logic        target_mem_type,
  output logic [8:0]  target_addr,
  output logic [31:0] uart_rx_data_in,
  output logic        rw_flag,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_ISSUE, S_WAIT_RD, S_TX, S_ACK
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  tx_cnt_q, tx_cnt_d;
  logic        mem_type_q, mem_type_d;
  logic [8:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;
  logic [41:0] rdata_q, rdata_d;
  logic        nak_q, nak_d;
  logic [7:0]  tx_byte;
  logic        tmo_hit;

  assign target_mem_type = mem_type_q;
  assign target_addr     = addr_q;
  assign rw_flag         = rw_q;
  assign uart_rx_data_in = wdata_q;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          waiting;

  // Counts idle cycles while a frame or read response is outstanding.
  // Any rx byte and every non-waiting state reload it, so entering WAIT_RD
  // from ISSUE starts from zero.
  always_comb begin
    waiting = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) ||
              (state_q == S_DATA) || (state_q == S_WAIT_RD);
    tmo_hit = waiting && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    if (rx_valid || !waiting) begin
      tmo_d = '0;
    end else if (tmo_hit) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_hit = 1'b0;
`endif

  // Read-back is sent as {6'b0, word}, most significant byte first.
  always_comb begin
    tx_byte = rdata_q[7:0];
    case (tx_cnt_q)
      3'd0:    tx_byte = {6'b0, rdata_q[41:40]};
      3'd1:    tx_byte = rdata_q[39:32];
      3'd2:    tx_byte = rdata_q[31:24];
      3'd3:    tx_byte = rdata_q[23:16];
      3'd4:    tx_byte = rdata_q[15:8];
      default: tx_byte = rdata_q[7:0];
    endcase
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    tx_cnt_d      = tx_cnt_q;
    mem_type_d    = mem_type_q;
    addr_d        = addr_q;
    rw_d          = rw_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    nak_d         = nak_q;
    write_mem_req = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    frame_err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data[7:4] == 4'hA) begin
            mem_type_d = rx_data[1];
            rw_d       = rx_data[0];
            state_d    = S_ADDR_HI;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      S_ADDR_HI: begin
        if (rx_valid) begin
          addr_d  = {rx_data[0], addr_q[7:0]};
          state_d = S_ADDR_LO;
        end else if (tmo_hit) begin
          frame_err = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_ADDR_LO: begin
        if (rx_valid) begin
          addr_d     = {addr_q[8], rx_data};
          byte_cnt_d = 2'd0;
          state_d    = rw_q ? S_DATA : S_ISSUE;
        end else if (tmo_hit) begin
          frame_err = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          wdata_d    = {wdata_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_ISSUE;
          end
        end else if (tmo_hit) begin
          frame_err = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_ISSUE: begin
        frame_err = rx_valid;
        if (enable) begin
          // CPU running: refuse the access and answer with NAK.
          frame_err = 1'b1;
          nak_d     = 1'b1;
          state_d   = S_ACK;
        end else begin
          write_mem_req = 1'b1;
          if (rw_q) begin
            nak_d   = 1'b0;
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT_RD;
          end
        end
      end
      S_WAIT_RD: begin
        frame_err = rx_valid;
        if (mem_tx_data_ready) begin
          rdata_d  = mem_tx_data_in;
          tx_cnt_d = 3'd0;
          state_d  = S_TX;
        end else if (tmo_hit) begin
          frame_err = 1'b1;
          nak_d     = 1'b1;
          state_d   = S_ACK;
        end
      end
      S_TX: begin
        frame_err = rx_valid;
        tx_valid  = 1'b1;
        tx_data   = tx_byte;
        if (tx_ready) begin
          if (tx_cnt_q == 3'd5) begin
            tx_cnt_d = 3'd0;
            state_d  = S_IDLE;
          end else begin
            tx_cnt_d = tx_cnt_q + 3'd1;
          end
        end
      end
      S_ACK: begin
        frame_err = rx_valid;
        tx_valid  = 1'b1;
        tx_data   = nak_q ? 8'hEE : 8'h55;
        if (tx_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      tx_cnt_q   <= 3'd0;
      mem_type_q <= 1'b0;
      addr_q     <= 9'd0;
      rw_q       <= 1'b0;
      wdata_q    <= 32'd0;
      rdata_q    <= 42'd0;
      nak_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      mem_type_q <= mem_type_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      nak_q      <= nak_d;
    end
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, inter-byte/response timeout in clk cycles (used only with CMD_TIMEOUT_EN).
REQ-002 SHALL have ports as listed in REQ-003 to REQ-017; one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  byte from UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data valid.
REQ-007 enable  input  1  CPU run flag; memory access allowed only when 0.
REQ-008 mem_tx_data_in  input  42  read-back word {valid, addr[8:0], data[31:0]} from target memory.
REQ-009 mem_tx_data_ready  input  1  read-back valid strobe, OR of instruction/data memory ready.
REQ-010 tx_ready  input  1  UART transmitter can accept a byte.
REQ-011 write_mem_req  output  1  one-cycle memory access request.
REQ-012 target_mem_type  output  1  1 = instruction memory, 0 = data memory.
REQ-013 target_addr  output  9  word address.
REQ-014 uart_rx_data_in  output  32  write data.
REQ-015 rw_flag  output  1  1 = write, 0 = read.
REQ-016 tx_data / tx_valid  output  8 / 1  byte to UART transmitter; transfer when tx_valid and tx_ready both high.
REQ-017 frame_err  output  1  one-cycle pulse on any rejected, overrun or timed-out frame.

Function
REQ-018 Frame SHALL be: CMD, ADDR_HI, ADDR_LO, then 4 data bytes MSB-first for writes only.
REQ-019 CMD[7:4] SHALL equal 4'hA; CMD[1] gives target_mem_type; CMD[0] gives rw_flag; CMD[3:2] ignored.
REQ-020 A CMD byte with CMD[7:4] other than 4'hA SHALL be discarded, pulse frame_err, and stay in IDLE.
REQ-021 target_addr SHALL be {ADDR_HI[0], ADDR_LO}; ADDR_HI[7:1] ignored.
REQ-022 States SHALL be IDLE, ADDR_HI, ADDR_LO, DATA (2-bit byte counter 0..3), ISSUE, WAIT_RD, TX (3-bit byte counter 0..5), ACK.
REQ-023 On entering ISSUE with enable=0, write_mem_req SHALL be 1 for exactly one cycle; target_* , rw_flag and uart_rx_data_in SHALL be stable that cycle and hold until the next frame.
REQ-024 On entering ISSUE with enable=1, no request SHALL be issued; frame_err SHALL pulse; ACK SHALL send byte 0xEE (NAK).
REQ-025 A write SHALL go ISSUE -> ACK and send byte 0x55.
REQ-026 A read SHALL go ISSUE -> WAIT_RD; on mem_tx_data_ready it SHALL latch mem_tx_data_in and go to TX.
REQ-027 TX SHALL send {6'b0, latched 42 bits} as 6 bytes MSB-first, one byte per tx handshake, then return to IDLE.
REQ-028 tx_valid SHALL stay high with tx_data stable until tx_ready; no byte SHALL be dropped or repeated.
REQ-029 rx_valid in ISSUE, WAIT_RD, TX or ACK SHALL be ignored and pulse frame_err (overrun); the FSM SHALL not leave its state.
REQ-030 mem_tx_data_ready outside WAIT_RD SHALL be ignored.
REQ-031 Latency: last frame byte at cycle N -> write_mem_req at N+1; first tx_valid for a write at N+2.

Reset
REQ-032 Reset SHALL force IDLE, counters 0, and outputs: write_mem_req=0, target_mem_type=0, target_addr=0, uart_rx_data_in=0, rw_flag=0, tx_data=0, tx_valid=0, frame_err=0.
REQ-033 Reset mid-frame or mid-TX SHALL abort the frame; no request or further byte SHALL follow.

Configuration
REQ-034 With CMD_TIMEOUT_EN defined: a counter SHALL reload on every accepted rx byte and on entering WAIT_RD; reaching TIMEOUT_CYCLES in ADDR_HI/ADDR_LO/DATA SHALL return to IDLE with frame_err; in WAIT_RD SHALL pulse frame_err and send NAK 0xEE.
REQ-035 Without CMD_TIMEOUT_EN: no counter SHALL be built; the FSM SHALL wait indefinitely.

Verification
REQ-036 Write: enable=0, bytes A3 01 2C DE AD BE EF -> one-cycle write_mem_req, type=1, rw=1, addr=0x12C, data=0xDEADBEEF; tx 0x55.
REQ-037 Read: bytes A2 00 05, ready with 42'h2_05_00000013 (valid=1, addr=0x005) two cycles later -> tx 02 05 00 00 00 13.
REQ-038 Halted check: enable=1, bytes A1 00 10 + 4 data -> no write_mem_req, frame_err pulse, tx 0xEE.
REQ-039 Bad sync: byte 0x53 -> frame_err pulse, next A2 00 01 processed normally.
REQ-040 Backpressure/overrun: tx_ready low 10 cycles during read response, rx_valid injected -> bytes unchanged, frame_err pulse, all 6 bytes delivered in order.
REQ-041 Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16): A3 00 then silence 16 cycles -> frame_err, IDLE; reset asserted mid-DATA -> all outputs at reset values, no request.
